ocra1_serialiser: RTL and testbench

OCRA1_SERIALISER -- requirements
Module: ocra1_serialiser

---
 rtl/ocra1_serialiser_pkg.sv | 22 ++
 rtl/spi_half_tick.sv | 26 ++
 rtl/ocra1_serialiser.sv | 182 ++++++++++++++++++
 tb/tb_ocra1_serialiser.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ocra1_serialiser_pkg.sv
// Shared types and word formatting for the OCRA1 gradient DAC serialiser.
package ocra1_pkg;

   localparam int unsigned WORD_BITS = 24;
   localparam int unsigned DATA_BITS = 18;
   localparam int unsigned BIT_CNT_W = 5;
   localparam logic [2:0]  DAC_DATA_ADDR = 3'b001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SHIFT,
      ST_GAP,
      ST_LDAC
   } state_t;

   // DAC data-register write: R/W=0, address, 18-bit code, two don't-care LSBs
   function automatic logic [WORD_BITS-1:0] fmt_word(input logic [DATA_BITS-1:0] data);
      return {1'b0, DAC_DATA_ADDR, data, 2'b00};
   endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period strobe generator: one tick every div+1 cycles while enabled.
module spi_half_tick #(
   parameter int unsigned DIV_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q;

   assign tick = en && (cnt_q == div);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/ocra1_serialiser.sv
// Four-lane lockstep SPI serialiser for the OCRA1 gradient DAC board.
module ocra1_serialiser
   import ocra1_pkg::*;
#(
   parameter int unsigned CH_NUM = 4,
   parameter int unsigned DIV_W  = 6
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [CH_NUM-1:0][DATA_BITS-1:0]     data_i,
   input  logic [CH_NUM-1:0][WORD_BITS-1:0]     raw_i,
   input  logic                                 raw_mode_i,
   input  logic                                 ldac_i,
   input  logic [DIV_W-1:0]                     div_i,
   input  logic                                 valid_i,
   output logic                                 ready_o,
   output logic                                 busy_err_o,
   output logic                                 ocra1_clk_o,
   output logic                                 ocra1_syncn_o,
   output logic                                 ocra1_ldacn_o,
   output logic                                 ocra1_sdox_o,
   output logic                                 ocra1_sdoy_o,
   output logic                                 ocra1_sdoz_o,
   output logic                                 ocra1_sdoz2_o
);

   state_t                             state_q, state_d;
   logic [CH_NUM-1:0][WORD_BITS-1:0]   word_q, word_d;
   logic [DIV_W-1:0]                   div_q, div_d;
   logic                               ldac_q, ldac_d;
   logic [BIT_CNT_W-1:0]               bit_cnt_q, bit_cnt_d;
   logic                               sclk_q, sclk_d;
   logic                               syncn_q, syncn_d;
   logic                               ldacn_q, ldacn_d;
   logic                               ready_q, ready_d;
   logic                               busy_err_q, busy_err_d;
   logic [CH_NUM-1:0]                  sdo_q, sdo_d;
   logic [BIT_CNT_W-1:0]               next_bit, next_idx;
   logic                               tick_en, tick;

   assign tick_en = (state_q != ST_IDLE);

   spi_half_tick #(.DIV_W(DIV_W)) u_half_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .div  (div_q),
      .tick (tick)
   );

   // Next-state and next-output logic; all pins come straight from flops
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      div_d      = div_q;
      ldac_d     = ldac_q;
      bit_cnt_d  = bit_cnt_q;
      sclk_d     = sclk_q;
      syncn_d    = syncn_q;
      ldacn_d    = ldacn_q;
      ready_d    = ready_q;
      sdo_d      = sdo_q;
      busy_err_d = valid_i && !ready_q;
      next_bit   = bit_cnt_q + BIT_CNT_W'(1);
      next_idx   = BIT_CNT_W'(WORD_BITS - 1) - next_bit;

      case (state_q)
         ST_IDLE: begin
            if (valid_i && ready_q) begin
               for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
                  word_d[ch] = raw_mode_i ? raw_i[ch] : fmt_word(data_i[ch]);
                  sdo_d[ch]  = word_d[ch][WORD_BITS-1];
               end
               div_d     = div_i;
               ldac_d    = ldac_i;
               bit_cnt_d = '0;
               sclk_d    = 1'b0;
               syncn_d   = 1'b0;
               ready_d   = 1'b0;
               state_d   = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (tick) begin
               sclk_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Data only moves on the rising half, one full half after the slave's falling-edge sample
            if (tick) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
               end else if (bit_cnt_q == BIT_CNT_W'(WORD_BITS - 1)) begin
                  syncn_d   = 1'b1;
                  sdo_d     = '0;
                  bit_cnt_d = '0;
                  state_d   = ST_GAP;
               end else begin
                  sclk_d    = 1'b1;
                  bit_cnt_d = next_bit;
                  for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
                     sdo_d[ch] = word_q[ch][next_idx];
                  end
               end
            end
         end
         ST_GAP: begin
            if (tick) begin
               if (ldac_q) begin
                  ldacn_d = 1'b0;
                  state_d = ST_LDAC;
               end else begin
                  ready_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_LDAC: begin
            // bit_cnt is idle here, so it doubles as the two-half LDAC counter
            if (tick) begin
               if (bit_cnt_q == '0) begin
                  bit_cnt_d = BIT_CNT_W'(1);
               end else begin
                  bit_cnt_d = '0;
                  ldacn_d   = 1'b1;
                  ready_d   = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sclk_d    = 1'b0;
            syncn_d   = 1'b1;
            ldacn_d   = 1'b1;
            sdo_d     = '0;
            ready_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         div_q      <= '0;
         ldac_q     <= 1'b0;
         bit_cnt_q  <= '0;
         sclk_q     <= 1'b0;
         syncn_q    <= 1'b1;
         ldacn_q    <= 1'b1;
         ready_q    <= 1'b1;
         busy_err_q <= 1'b0;
         sdo_q      <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         div_q      <= div_d;
         ldac_q     <= ldac_d;
         bit_cnt_q  <= bit_cnt_d;
         sclk_q     <= sclk_d;
         syncn_q    <= syncn_d;
         ldacn_q    <= ldacn_d;
         ready_q    <= ready_d;
         busy_err_q <= busy_err_d;
         sdo_q      <= sdo_d;
      end
   end

   assign ready_o       = ready_q;
   assign busy_err_o    = busy_err_q;
   assign ocra1_clk_o   = sclk_q;
   assign ocra1_syncn_o = syncn_q;
   assign ocra1_ldacn_o = ldacn_q;
   assign ocra1_sdox_o  = sdo_q[0];
   assign ocra1_sdoy_o  = sdo_q[1];
   assign ocra1_sdoz_o  = sdo_q[2];
   assign ocra1_sdoz2_o = sdo_q[3];

endmodule

// File: tb/tb_ocra1_serialiser.sv
// Bench for ocra1_serialiser: captures each frame as a slave would and checks it against the word rules.
module tb_ocra1_serialiser;

   localparam int unsigned CH = 4;
   localparam int unsigned DW = 6;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [CH-1:0][17:0]   data_i;
   logic [CH-1:0][23:0]   raw_i;
   logic                  raw_mode_i;
   logic                  ldac_i;
   logic [DW-1:0]         div_i;
   logic                  valid_i;
   logic                  ready_o, busy_err_o;
   logic                  ocra1_clk_o, ocra1_syncn_o, ocra1_ldacn_o;
   logic                  ocra1_sdox_o, ocra1_sdoy_o, ocra1_sdoz_o, ocra1_sdoz2_o;
   logic [3:0]            sdo;

   int n_checks = 0;
   int n_errors = 0;
   logic [23:0] cap_g [CH];

   assign sdo = {ocra1_sdoz2_o, ocra1_sdoz_o, ocra1_sdoy_o, ocra1_sdox_o};

   always #5 clk = ~clk;

   ocra1_serialiser #(.CH_NUM(CH), .DIV_W(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .data_i        (data_i),
      .raw_i         (raw_i),
      .raw_mode_i    (raw_mode_i),
      .ldac_i        (ldac_i),
      .div_i         (div_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .busy_err_o    (busy_err_o),
      .ocra1_clk_o   (ocra1_clk_o),
      .ocra1_syncn_o (ocra1_syncn_o),
      .ocra1_ldacn_o (ocra1_ldacn_o),
      .ocra1_sdox_o  (ocra1_sdox_o),
      .ocra1_sdoy_o  (ocra1_sdoy_o),
      .ocra1_sdoz_o  (ocra1_sdoz_o),
      .ocra1_sdoz2_o (ocra1_sdoz2_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference word: raw passes through; formatted is address 001 at bit 20 plus code*4
   function automatic logic [23:0] model_word(input bit raw_mode, input logic [23:0] raw,
                                              input logic [17:0] d);
      if (raw_mode) return raw;
      return 24'(32'h0010_0000 + 32'(d) * 32'd4);
   endfunction

   task automatic rand_inputs(input int div_max);
      for (int ch = 0; ch < int'(CH); ch++) begin
         data_i[ch] = 18'($urandom_range(0, 262143));
         raw_i[ch]  = 24'($urandom);
      end
      raw_mode_i = 1'($urandom_range(0, 1));
      ldac_i     = 1'($urandom_range(0, 1));
      div_i      = DW'($urandom_range(0, div_max));
   endtask

   // Issue one request and watch the pins until ready returns.
   // inj_kind: 0 none, 1 pulse valid at inj_cyc, 2 change div_i to 5, 3 reset at inj_cyc
   task automatic run_frame(input string tag, input int inj_cyc, input int inj_kind, input bit hold);
      logic [23:0] exp_w [CH];
      logic [23:0] cap [CH];
      int   divc, exp_busy, exp_berr;
      bit   ldacc;
      int   busy = 0, sync_low = 0, ldac_low = 0, berr = 0;
      int   hi_run = 0, hi_runs = 0, hi_bad = 0, idle_bad = 0;
      logic prev_sclk = 1'b0;
      bit   done = 1'b0;
      for (int ch = 0; ch < int'(CH); ch++) begin
         exp_w[ch] = model_word(raw_mode_i, raw_i[ch], data_i[ch]);
         cap[ch]   = '0;
      end
      divc     = int'(div_i);
      ldacc    = ldac_i;
      exp_busy = (ldacc ? 52 : 50) * (divc + 1);
      exp_berr = hold ? exp_busy - 1 : (inj_kind == 1 ? 1 : 0);
      valid_i  = 1'b1;
      @(negedge clk);
      if (!hold) valid_i = 1'b0;
      for (int cyc = 1; cyc <= 60 * (divc + 1) + 20; cyc++) begin
         if (ready_o) begin
            done = 1'b1;
            break;
         end
         busy++;
         if (!ocra1_syncn_o) sync_low++;
         if (!ocra1_ldacn_o) ldac_low++;
         if (busy_err_o) berr++;
         if (ocra1_clk_o) begin
            hi_run++;
         end else if (prev_sclk) begin
            hi_runs++;
            if (hi_run != divc + 1) hi_bad++;
            hi_run = 0;
            for (int ch = 0; ch < int'(CH); ch++) cap[ch] = {cap[ch][22:0], sdo[ch]};
         end
         prev_sclk = ocra1_clk_o;
         if (inj_kind == 1 && cyc == inj_cyc) valid_i = 1'b1;
         if (inj_kind == 1 && cyc == inj_cyc + 1) valid_i = 1'b0;
         if (inj_kind == 2 && cyc == inj_cyc) div_i = DW'(5);
         if (inj_kind == 3 && cyc == inj_cyc) begin
            rst = 1'b1;
            @(negedge clk);
            chk({tag, "/rst_syncn"}, 32'(ocra1_syncn_o), 32'd1);
            chk({tag, "/rst_sclk"},  32'(ocra1_clk_o),   32'd0);
            chk({tag, "/rst_ldacn"}, 32'(ocra1_ldacn_o), 32'd1);
            chk({tag, "/rst_ready"}, 32'(ready_o),       32'd1);
            chk({tag, "/rst_sdo"},   32'(sdo),           32'd0);
            rst = 1'b0;
            repeat (6) begin
               @(negedge clk);
               if (!ocra1_ldacn_o || !ocra1_syncn_o || !ready_o) idle_bad++;
            end
            chk({tag, "/post_rst_idle"}, idle_bad, 0);
            return;
         end
         @(negedge clk);
      end
      chk({tag, "/completed"}, 32'(done),   32'd1);
      chk({tag, "/busy_len"},  busy,        exp_busy);
      chk({tag, "/syncn_len"}, sync_low,    49 * (divc + 1));
      chk({tag, "/ldacn_len"}, ldac_low,    ldacc ? 2 * (divc + 1) : 0);
      chk({tag, "/sclk_hi"},   hi_runs,     24);
      chk({tag, "/half_len"},  hi_bad,      0);
      chk({tag, "/busy_err"},  berr,        exp_berr);
      chk({tag, "/sdo_idle"},  32'(sdo),    32'd0);
      for (int ch = 0; ch < int'(CH); ch++) begin
         chk($sformatf("%s/word%0d", tag, ch), 32'(cap[ch]), 32'(exp_w[ch]));
         cap_g[ch] = cap[ch];
      end
   endtask

   initial begin
      int nb;
      rst        = 1'b1;
      valid_i    = 1'b0;
      data_i     = '0;
      raw_i      = '0;
      raw_mode_i = 1'b0;
      ldac_i     = 1'b0;
      div_i      = '0;
      repeat (3) @(negedge clk);
      chk("reset/ready",    32'(ready_o),       32'd1);
      chk("reset/busy_err", 32'(busy_err_o),    32'd0);
      chk("reset/sclk",     32'(ocra1_clk_o),   32'd0);
      chk("reset/syncn",    32'(ocra1_syncn_o), 32'd1);
      chk("reset/ldacn",    32'(ocra1_ldacn_o), 32'd1);
      chk("reset/sdo",      32'(sdo),           32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Formatted, fastest clock, with LDAC
      rand_inputs(0);
      data_i[0] = 18'h1FFFF;
      data_i[1] = 18'h3FFFF;
      raw_mode_i = 1'b0;
      ldac_i     = 1'b1;
      div_i      = '0;
      run_frame("fmt_div0", 0, 0, 1'b0);
      chk("fmt_div0/x_literal", 32'(cap_g[0]), 32'h17FFFC);
      chk("fmt_div0/y_literal", 32'(cap_g[1]), 32'h1FFFFC);

      // Raw mode, 4-cycle halves, no LDAC
      rand_inputs(0);
      raw_i      = {4{24'h200012}};
      raw_mode_i = 1'b1;
      ldac_i     = 1'b0;
      div_i      = DW'(3);
      run_frame("raw_div3", 0, 0, 1'b0);
      for (int ch = 0; ch < int'(CH); ch++)
         chk($sformatf("raw_div3/literal%0d", ch), 32'(cap_g[ch]), 32'h200012);

      // Request while busy is dropped with a single error pulse
      rand_inputs(0);
      run_frame("busy_req", 10, 1, 1'b0);
      nb = 0;
      repeat (20) begin
         @(negedge clk);
         if (!ready_o || !ocra1_syncn_o) nb++;
      end
      chk("busy_req/no_second_frame", nb, 0);

      // Reset mid-frame, then a clean frame
      rand_inputs(0);
      ldac_i = 1'b1;
      run_frame("reset_mid", 26, 3, 1'b0);
      rand_inputs(2);
      run_frame("after_reset", 0, 0, 1'b0);

      // div_i change mid-frame only affects the following frame
      rand_inputs(0);
      run_frame("div_change", 20, 2, 1'b0);
      chk("div_change/input_now", 32'(div_i), 32'd5);
      run_frame("div5", 0, 0, 1'b0);

      repeat (6) begin
         rand_inputs(3);
         run_frame("random", 0, 0, 1'b0);
      end

      // valid_i held high across back-to-back frames
      for (int k = 0; k < 3; k++) begin
         rand_inputs(1);
         run_frame($sformatf("held%0d", k), 0, 0, k < 2);
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
